hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised load-use hazard unit for the WISC pipeline, sitting beside the decode stage. It replaces the single-cycle ID/EX compare with a per-register scoreboard of pending-load countdowns, so it handles memory latencies longer than one cycle. It drives the IF/ID stall and keeps a saturating stall-cycle performance counter. With `LOAD_LAT=1` and `STORE_FWD=1` it reproduces the current one-bubble load-use policy, including the store-data exemption.

## Interface
Parameters:
- `REG_AW`, 4, register address width
- `NUM_REGS`, 16, architectural registers (≤ 2^REG_AW)
- `LOAD_LAT`, 1, cycles after load issue before its result is forwardable (≥1)
- `STORE_FWD`, 1, 1 = store data source (Rt) exempt from stall when its producer load result arrives next cycle (MEM-to-MEM forward)
- `CNT_W`, 16, stall counter width

Ports (reset is synchronous and active-low; single clock):
- `clk` in 1 system clock
- `rst_n` in 1 synchronous active-low reset
- `flush` in 1 squash the instruction in ID this cycle
- `id_valid` in 1 instruction in IF/ID is valid
- `id_rs` in REG_AW source 1
- `id_rs_used` in 1 source 1 is read
- `id_rt` in REG_AW source 2 / store data
- `id_rt_used` in 1 source 2 is read
- `id_is_load` in 1 instruction is a load (LW)
- `id_is_store` in 1 instruction is a store (SW)
- `id_rd` in REG_AW load destination
- `stall` out 1 hold PC and IF/ID, insert bubble into ID/EX
- `busy_vec` out NUM_REGS bit r = register r has a pending load
- `stall_count` out CNT_W saturating count of stall cycles

## Operation
- Scoreboard: one down-counter `cnt[r]` per register, width clog2(LOAD_LAT+1). `busy_vec[r] = (cnt[r] != 0)`.
- Register 0 is never busy. Loads to r0 do not set it, and sources of r0 never hazard.
- Hazard on source s (rs or rt): `id_valid & s_used & s != 0 & cnt[s] != 0`.
- Store exemption: when `STORE_FWD=1`, `id_is_store`, and `cnt[id_rt] == 1`, the rt hazard is suppressed. The rs (address) hazard still applies.
- `stall` = OR of source hazards. It is combinational from the inputs and registered counters, and is forced 0 while `flush=1`.
- Issue occurs when `id_valid & ~stall & ~flush`. An issuing load with `id_rd != 0` loads `cnt[id_rd] <= LOAD_LAT`.
- Every cycle, each nonzero counter not being loaded decrements by 1. Load-set wins over decrement on the same register.
- Flush does not clear the scoreboard. Loads older than the flush still complete, so the behaviour stays conservative.
- `stall_count` increments on each cycle with `stall=1` and saturates at all-ones (no wrap).

## Timing
- Reset (`rst_n=0` at a rising edge): all `cnt` are 0, so `busy_vec=0` and `stall=0`, and `stall_count=0`. Reset mid-countdown discards pending loads.
- A load issued in cycle t is busy in cycles t+1 … t+LOAD_LAT. A dependent instruction in ID stalls in those cycles and issues in t+LOAD_LAT+1.
- With LOAD_LAT=1, a back-to-back dependent instruction gets exactly one bubble.
- A stalled instruction re-evaluates every cycle with no extra latency.
- `busy_vec` and `stall_count` are registered. `stall` has zero-cycle latency.

## Structure
- `hazard_pkg`: opcode constants (LW=4'b1000, SW=4'b1001), default `LOAD_LAT`, and a `cnt_t` width function.
- Sub-module `hazard_sb_entry`: one counter with set/decrement/reset, instantiated NUM_REGS−1 times via generate (r0 tied off).
- Top: source compare muxes, store exemption, issue logic, stall counter.

## Test plan
- LOAD_LAT=1: LW r3 issues, next instruction is ADD using rs=r3 → `stall=1` for 1 cycle, ADD issues the following cycle, `stall_count=1`.
- LOAD_LAT=1, STORE_FWD=1: LW r5 then SW with rt=r5, rs=r2 → no stall. Repeat with SW rs=r5 → 1-cycle stall.
- LOAD_LAT=3: LW r7 then ADD rt=r7 → `stall=1` for 3 cycles, `busy_vec[7]` is 1 for those 3 cycles, then clears.
- LW r0 followed by a use of r0 → no stall, and `busy_vec` stays 0.
- `flush=1` on a cycle where the instruction in ID is a load → `stall=0`, no counter set. A pending older load still counts down and stalls its dependent.
- Force the hazard for 2^CNT_W+5 cycles (CNT_W=4) → `stall_count` holds 15. Asserting `rst_n=0` mid-countdown → next cycle `busy_vec=0`, `stall=0`, `stall_count=0`.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the load-use hazard scoreboard.
package hazard_pkg;

   localparam logic [3:0] OP_LW        = 4'b1000;
   localparam logic [3:0] OP_SW        = 4'b1001;
   localparam int         DEF_LOAD_LAT = 1;

   // Bits needed to hold a countdown from lat down to 0.
   function automatic int cnt_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: pending-load countdown for a single architectural register.
module hazard_sb_entry
   import hazard_pkg::*;
#(
   parameter int CW  = 1,
   parameter int LAT = DEF_LOAD_LAT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set,
   output logic [CW-1:0] cnt
);

   // A new load to this register restarts the countdown even if one is pending.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (set) begin
         cnt <= CW'(LAT);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit beside decode: per-register pending-load scoreboard, IF/ID stall, stall counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW    = 4,
   parameter int NUM_REGS  = 16,
   parameter int LOAD_LAT  = DEF_LOAD_LAT,
   parameter int STORE_FWD = 1,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                id_valid,
   input  logic [REG_AW-1:0]   id_rs,
   input  logic                id_rs_used,
   input  logic [REG_AW-1:0]   id_rt,
   input  logic                id_rt_used,
   input  logic                id_is_load,
   input  logic                id_is_store,
   input  logic [REG_AW-1:0]   id_rd,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]    stall_count
);

   localparam int CW    = cnt_width(LOAD_LAT);
   localparam int NSLOT = 2 ** REG_AW;

   // Sized to the full address space so any source address indexes safely.
   logic [CW-1:0] cnt [NSLOT];
   logic [CW-1:0] rs_cnt;
   logic [CW-1:0] rt_cnt;
   logic          rs_haz;
   logic          rt_haz;
   logic          rt_exempt;
   logic          issue;
   logic          ld_issue;

   assign cnt[0] = '0;

   for (genvar r = 1; r < NSLOT; r++) begin : g_entry
      if (r < NUM_REGS) begin : g_live
         hazard_sb_entry #(
            .CW  (CW),
            .LAT (LOAD_LAT)
         ) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .set   (ld_issue && (id_rd == REG_AW'(r))),
            .cnt   (cnt[r])
         );
      end else begin : g_tie
         assign cnt[r] = '0;
      end
   end

   always_comb begin
      busy_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_vec[r] = (cnt[r] != '0);
      end
   end

   assign rs_cnt = cnt[id_rs];
   assign rt_cnt = cnt[id_rt];

   assign rs_haz = id_valid && id_rs_used && (id_rs != '0) && (rs_cnt != '0);

   // Store data arriving next cycle is caught by the MEM-to-MEM forward path.
   assign rt_exempt = (STORE_FWD != 0) && id_is_store && (rt_cnt == CW'(1));
   assign rt_haz    = id_valid && id_rt_used && (id_rt != '0) && (rt_cnt != '0) && !rt_exempt;

   assign stall    = (rs_haz || rt_haz) && !flush;
   assign issue    = id_valid && !stall && !flush;
   assign ld_issue = issue && id_is_load && (id_rd != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: scripted instruction stream, expected outputs queued per cycle.
module tb_hazard_scoreboard;

   typedef struct {
      string       tag;
      bit          sel_b;
      logic        stall;
      logic [15:0] busy;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        id_valid;
   logic [3:0]  id_rs;
   logic        id_rs_used;
   logic [3:0]  id_rt;
   logic        id_rt_used;
   logic        id_is_load;
   logic        id_is_store;
   logic [3:0]  id_rd;

   logic        stall_a;
   logic [15:0] busy_a;
   logic [3:0]  cnt_a;
   logic        stall_b;
   logic [15:0] busy_b;
   logic [15:0] cnt_b;

   exp_t q[$];
   bit   sel_b;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .REG_AW(4), .NUM_REGS(16), .LOAD_LAT(1), .STORE_FWD(1), .CNT_W(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_is_load(id_is_load), .id_is_store(id_is_store), .id_rd(id_rd),
      .stall(stall_a), .busy_vec(busy_a), .stall_count(cnt_a)
   );

   hazard_scoreboard #(
      .REG_AW(4), .NUM_REGS(16), .LOAD_LAT(3), .STORE_FWD(1), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_is_load(id_is_load), .id_is_store(id_is_store), .id_rd(id_rd),
      .stall(stall_b), .busy_vec(busy_b), .stall_count(cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [3:0] rs, input logic rsu,
                      input logic [3:0] rt, input logic rtu, input logic ld,
                      input logic st, input logic [3:0] rd, input logic fl);
      id_valid    = v;
      id_rs       = rs;
      id_rs_used  = rsu;
      id_rt       = rt;
      id_rt_used  = rtu;
      id_is_load  = ld;
      id_is_store = st;
      id_rd       = rd;
      flush       = fl;
   endtask

   task automatic push(input string tag, input logic s, input logic [15:0] bv, input logic [15:0] sc);
      exp_t e;
      e.tag   = tag;
      e.sel_b = sel_b;
      e.stall = s;
      e.busy  = bv;
      e.cnt   = sc;
      q.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (q.size() == 0) begin
         chk("queue_underflow", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         if (e.sel_b) begin
            chk({e.tag, "_stall"}, {31'd0, stall_b}, {31'd0, e.stall});
            chk({e.tag, "_busy"},  {16'd0, busy_b},  {16'd0, e.busy});
            chk({e.tag, "_count"}, {16'd0, cnt_b},   {16'd0, e.cnt});
         end else begin
            chk({e.tag, "_stall"}, {31'd0, stall_a}, {31'd0, e.stall});
            chk({e.tag, "_busy"},  {16'd0, busy_a},  {16'd0, e.busy});
            chk({e.tag, "_count"}, {28'd0, cnt_a},   {16'd0, e.cnt});
         end
      end
      @(posedge clk);
      #1;
   endtask

   // One cycle: drive ID contents, queue what the selected DUT must show, then clock.
   task automatic cyc(input string tag, input logic v, input logic [3:0] rs, input logic rsu,
                      input logic [3:0] rt, input logic rtu, input logic ld, input logic st,
                      input logic [3:0] rd, input logic fl,
                      input logic s, input logic [15:0] bv, input logic [15:0] sc);
      drv(v, rs, rsu, rt, rtu, ld, st, rd, fl);
      push(tag, s, bv, sc);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      sel_b = 1'b0;
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      cyc("reset_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 16'd0);
      rst_n = 1'b1;

      // LOAD_LAT=1: one bubble for back-to-back use
      cyc("lw_r3",       1, 0, 0, 0, 0, 1, 0, 3, 0, 1'b0, 16'h0000, 16'd0);
      cyc("add_r3_stl",  1, 3, 1, 1, 1, 0, 0, 9, 0, 1'b1, 16'h0008, 16'd0);
      cyc("add_r3_iss",  1, 3, 1, 1, 1, 0, 0, 9, 0, 1'b0, 16'h0000, 16'd1);
      cyc("idle1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 16'd1);

      // Store data exemption, then address hazard on the same load
      cyc("lw_r5",       1, 0, 0, 0, 0, 1, 0, 5, 0, 1'b0, 16'h0000, 16'd1);
      cyc("sw_rt5",      1, 2, 1, 5, 1, 0, 1, 0, 0, 1'b0, 16'h0020, 16'd1);
      cyc("lw_r5b",      1, 0, 0, 0, 0, 1, 0, 5, 0, 1'b0, 16'h0000, 16'd1);
      cyc("sw_rs5_stl",  1, 5, 1, 2, 1, 0, 1, 0, 0, 1'b1, 16'h0020, 16'd1);
      cyc("sw_rs5_iss",  1, 5, 1, 2, 1, 0, 1, 0, 0, 1'b0, 16'h0000, 16'd2);

      // r0 is never busy
      cyc("lw_r0",       1, 0, 0, 0, 0, 1, 0, 0, 0, 1'b0, 16'h0000, 16'd2);
      cyc("use_r0",      1, 0, 1, 0, 1, 0, 0, 4, 0, 1'b0, 16'h0000, 16'd2);

      // Flushed load: no stall even though its base is busy, and no counter set
      cyc("lw_r4",       1, 0, 0, 0, 0, 1, 0, 4, 0, 1'b0, 16'h0000, 16'd2);
      cyc("flush_lw_r6", 1, 4, 1, 0, 0, 1, 0, 6, 1, 1'b0, 16'h0010, 16'd2);
      cyc("use_r6",      1, 6, 1, 0, 0, 0, 0, 1, 0, 1'b0, 16'h0000, 16'd2);

      // Saturation of the 4-bit counter
      for (int k = 0; k < 21; k++) begin
         c = (2 + k > 15) ? 15 : 2 + k;
         cyc("sat_lw",  1, 0, 0, 0, 0, 1, 0, 3, 0, 1'b0, 16'h0000, 16'(c));
         cyc("sat_stl", 1, 3, 1, 0, 0, 0, 0, 1, 0, 1'b1, 16'h0008, 16'(c));
         c = (3 + k > 15) ? 15 : 3 + k;
         cyc("sat_iss", 1, 3, 1, 0, 0, 0, 0, 1, 0, 1'b0, 16'h0000, 16'(c));
      end
      cyc("sat_hold",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 16'd15);

      // LOAD_LAT=3 instance
      sel_b = 1'b1;
      rst_n = 1'b0;
      cyc("reset_b_in",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, cnt_b);
      rst_n = 1'b1;
      q.delete();
      cyc("reset_b",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 16'd0);

      cyc("b_lw_r7",     1, 0, 0, 0, 0, 1, 0, 7, 0, 1'b0, 16'h0000, 16'd0);
      cyc("b_add_s1",    1, 1, 1, 7, 1, 0, 0, 8, 0, 1'b1, 16'h0080, 16'd0);
      cyc("b_add_s2",    1, 1, 1, 7, 1, 0, 0, 8, 0, 1'b1, 16'h0080, 16'd1);
      cyc("b_add_s3",    1, 1, 1, 7, 1, 0, 0, 8, 0, 1'b1, 16'h0080, 16'd2);
      cyc("b_add_iss",   1, 1, 1, 7, 1, 0, 0, 8, 0, 1'b0, 16'h0000, 16'd3);

      // Store data waits until its load is one cycle from arriving
      cyc("b_lw_r7b",    1, 0, 0, 0, 0, 1, 0, 7, 0, 1'b0, 16'h0000, 16'd3);
      cyc("b_sw_c3",     1, 1, 1, 7, 1, 0, 1, 0, 0, 1'b1, 16'h0080, 16'd3);
      cyc("b_sw_c2",     1, 1, 1, 7, 1, 0, 1, 0, 0, 1'b1, 16'h0080, 16'd4);
      cyc("b_sw_c1",     1, 1, 1, 7, 1, 0, 1, 0, 0, 1'b0, 16'h0080, 16'd5);
      cyc("b_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 16'd5);

      // Older load survives a flush and still stalls its dependent
      cyc("b_lw_r4",     1, 0, 0, 0, 0, 1, 0, 4, 0, 1'b0, 16'h0000, 16'd5);
      cyc("b_flush",     1, 4, 1, 0, 0, 1, 0, 6, 1, 1'b0, 16'h0010, 16'd5);
      cyc("b_dep_s1",    1, 4, 1, 0, 0, 0, 0, 2, 0, 1'b1, 16'h0010, 16'd5);
      cyc("b_dep_s2",    1, 4, 1, 0, 0, 0, 0, 2, 0, 1'b1, 16'h0010, 16'd6);
      cyc("b_dep_iss",   1, 4, 1, 0, 0, 0, 0, 2, 0, 1'b0, 16'h0000, 16'd7);
      cyc("b_use_r6",    1, 6, 1, 0, 0, 0, 0, 2, 0, 1'b0, 16'h0000, 16'd7);

      // Reset in the middle of a countdown
      cyc("b_lw_r9",     1, 0, 0, 0, 0, 1, 0, 9, 0, 1'b0, 16'h0000, 16'd7);
      rst_n = 1'b0;
      cyc("b_rst_cyc",   1, 9, 1, 0, 0, 0, 0, 2, 0, 1'b1, 16'h0200, 16'd7);
      rst_n = 1'b1;
      cyc("b_post_rst",  1, 9, 1, 0, 0, 0, 0, 2, 0, 1'b0, 16'h0000, 16'd0);

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
